// File: rtl/bin2bcd_disp_feed.sv
// Sequential double-dabble converter feeding the 8-digit seven-segment driver.
// Ports: clk, rst (sync high), in_valid/in_ready/bin_in in; write_enable, data_to_led, ovf out.
module bin2bcd_disp_feed #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  write_enable,
  output logic [4*DIGITS-1:0]   data_to_led,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [63:0] MAX_DEC = (64'd10 ** DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_nx_q, ovf_nx_d;
  logic               we_q, we_d;
  logic [BCD_W-1:0]   data_q, data_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_sh;
  logic [3:0]         nib;

  // Add-3 per nibble (no inter-nibble carry), then one left shift
  always_comb begin
    bcd_adj = '0;
    nib     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    bcd_sh = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    ovf_nx_d = ovf_nx_q;
    we_d     = 1'b0;
    data_d   = data_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d    = bin_in;
          bcd_d    = '0;
          cnt_d    = '0;
          ovf_nx_d = 64'(bin_in) > MAX_DEC;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_sh;
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          we_d    = 1'b1;
          data_d  = ovf_nx_q ? {DIGITS{4'h9}} : bcd_sh;
          ovf_d   = ovf_nx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      ovf_nx_q <= 1'b0;
      we_q     <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      ovf_nx_q <= ovf_nx_d;
      we_q     <= we_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign write_enable = we_q;
  assign data_to_led  = data_q;
  assign ovf          = ovf_q;

endmodule
